// File: rtl/lsu_bus_arbiter.sv
// MEM-stage bus arbiter: shares the data-memory/IO bus between the CPU load/store
// port and a debug/DMA port, with one outstanding fixed-latency read and CPU stall.
module lsu_bus_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_req,
  input  logic        i_cpu_wren,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [2:0]  i_cpu_funct3,
  output logic        o_cpu_stall,
  output logic        o_cpu_rvalid,
  output logic [31:0] o_cpu_rdata,
  input  logic        i_dbg_req,
  input  logic        i_dbg_wren,
  input  logic [31:0] i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  output logic        o_dbg_gnt,
  output logic        o_dbg_rvalid,
  output logic [31:0] o_dbg_rdata,
  output logic        o_mem_en,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [2:0]  o_mem_funct3,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [2:0] RD_LAT_C     = 3'(RD_LAT);
  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);
  localparam logic [2:0] FUNCT3_WORD  = 3'b010;

  typedef enum logic {IDLE, RD_WAIT} state_e;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [2:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        dbg_wins;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      lat_q       <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    o_cpu_stall  = 1'b0;
    o_cpu_rvalid = 1'b0;
    o_dbg_gnt    = 1'b0;
    o_dbg_rvalid = 1'b0;
    o_mem_en     = 1'b0;
    o_mem_wren   = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_funct3 = '0;
    // DBG only overrides a competing CPU once it has been starved long enough
    dbg_wins     = i_dbg_req && (!i_cpu_req || (starve_q == STARVE_MAX_C));

    case (state_q)
      IDLE: begin
        if (dbg_wins) begin
          o_mem_en     = 1'b1;
          o_mem_wren   = i_dbg_wren;
          o_mem_addr   = i_dbg_addr;
          o_mem_wdata  = i_dbg_wdata;
          o_mem_funct3 = FUNCT3_WORD;
          o_dbg_gnt    = 1'b1;
          o_cpu_stall  = i_cpu_req;
          if (!i_dbg_wren) begin
            state_d = RD_WAIT;
            owner_d = OWN_DBG;
            lat_d   = RD_LAT_C;
          end
        end else if (i_cpu_req) begin
          o_mem_en     = 1'b1;
          o_mem_wren   = i_cpu_wren;
          o_mem_addr   = i_cpu_addr;
          o_mem_wdata  = i_cpu_wdata;
          o_mem_funct3 = i_cpu_funct3;
          if (!i_cpu_wren) begin
            state_d     = RD_WAIT;
            owner_d     = OWN_CPU;
            lat_d       = RD_LAT_C;
            o_cpu_stall = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          state_d = IDLE;
          if (owner_q == OWN_CPU) begin
            o_cpu_rvalid = 1'b1;
            cpu_rdata_d  = i_mem_rdata;
          end else begin
            o_dbg_rvalid = 1'b1;
            dbg_rdata_d  = i_mem_rdata;
          end
        end
        o_cpu_stall = i_cpu_req && !o_cpu_rvalid;
      end
    endcase

    // Return data is forwarded in the valid cycle, then held from the register
    o_cpu_rdata = o_cpu_rvalid ? i_mem_rdata : cpu_rdata_q;
    o_dbg_rdata = o_dbg_rvalid ? i_mem_rdata : dbg_rdata_q;

    if (!i_dbg_req || o_dbg_gnt) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX_C) begin
      starve_d = starve_q + 4'd1;
    end
  end

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// Directed self-checking bench for lsu_bus_arbiter; a second instance runs with
// a 3-cycle read latency for the reset-mid-read scenario.
module tb_lsu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wren;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic        dbg_req, dbg_wren;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [31:0] mem_rdata;

  logic        cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_wren;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;

  logic        cpu_stall3, cpu_rvalid3, dbg_gnt3, dbg_rvalid3;
  logic [31:0] cpu_rdata3, dbg_rdata3;
  logic        mem_en3, mem_wren3;
  logic [31:0] mem_addr3, mem_wdata3;
  logic [2:0]  mem_funct33;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  lsu_bus_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_wren(cpu_wren), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_funct3(cpu_funct3),
    .o_cpu_stall(cpu_stall), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_wren(dbg_wren), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
    .o_mem_en(mem_en), .o_mem_wren(mem_wren), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_funct3(mem_funct3),
    .i_mem_rdata(mem_rdata)
  );

  lsu_bus_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_wren(cpu_wren), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_funct3(cpu_funct3),
    .o_cpu_stall(cpu_stall3), .o_cpu_rvalid(cpu_rvalid3), .o_cpu_rdata(cpu_rdata3),
    .i_dbg_req(dbg_req), .i_dbg_wren(dbg_wren), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata),
    .o_dbg_gnt(dbg_gnt3), .o_dbg_rvalid(dbg_rvalid3), .o_dbg_rdata(dbg_rdata3),
    .o_mem_en(mem_en3), .o_mem_wren(mem_wren3), .o_mem_addr(mem_addr3),
    .o_mem_wdata(mem_wdata3), .o_mem_funct3(mem_funct33),
    .i_mem_rdata(mem_rdata)
  );

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
    dbg_req = 1'b0; dbg_wren = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic cpu_cmd(input logic wren, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
    cpu_req = 1'b1; cpu_wren = wren; cpu_addr = addr; cpu_wdata = wdata; cpu_funct3 = f3;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cpu_cmd(1'b0, 32'h0000_0080, '0, 3'b010);
    #1;
    chk_cnt++; if (cpu_stall !== 1'b1) $display("FAIL rst_pre_stall: got %b want 1", cpu_stall); else pass_cnt++;
    @(negedge clk);
    cpu_req = 1'b0; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk_cnt++; if (cpu_rvalid !== 1'b1) $display("FAIL rst_pre_rvalid: got %b want 1", cpu_rvalid); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    chk_cnt++; if (cpu_rvalid !== 1'b0) $display("FAIL rst_cpu_rvalid: got %b want 0", cpu_rvalid); else pass_cnt++;
    chk_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL rst_cpu_rdata: got %h want 00000000", cpu_rdata); else pass_cnt++;
    chk_cnt++; if ({cpu_stall, dbg_gnt, dbg_rvalid, mem_en, mem_wren} !== 5'b0)
      $display("FAIL rst_ctrl_outs: got %b want 00000", {cpu_stall, dbg_gnt, dbg_rvalid, mem_en, mem_wren}); else pass_cnt++;
    chk_cnt++; if ({mem_addr, mem_wdata, mem_funct3, dbg_rdata} !== '0)
      $display("FAIL rst_buses: got addr=%h wdata=%h f3=%b dbg_rdata=%h want all 0", mem_addr, mem_wdata, mem_funct3, dbg_rdata); else pass_cnt++;
    chk_cnt++; if ({cpu_rvalid3, mem_en3, cpu_stall3} !== 3'b0 || cpu_rdata3 !== 32'h0)
      $display("FAIL rst_dut3_outs: got rv=%b en=%b st=%b rdata=%h want 0", cpu_rvalid3, mem_en3, cpu_stall3, cpu_rdata3); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    cpu_cmd(1'b1, 32'h0000_00C0, 32'h1111_2222, 3'b010);
    #1;
    chk_cnt++; if (mem_en !== 1'b1 || mem_en3 !== 1'b1)
      $display("FAIL rst_idle_after: got en=%b en3=%b want 1 1", mem_en, mem_en3); else pass_cnt++;
    idle_cycles(1);
  endtask

  task automatic test_cpu_store();
    @(negedge clk);
    cpu_cmd(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010);
    #1;
    chk_cnt++; if ({mem_en, mem_wren, cpu_stall, cpu_rvalid} !== 4'b1100)
      $display("FAIL store_ctrl: got en/wren/stall/rvalid=%b want 1100", {mem_en, mem_wren, cpu_stall, cpu_rvalid}); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || mem_funct3 !== 3'b010)
      $display("FAIL store_bus: got addr=%h wdata=%h f3=%b want 00000100 deadbeef 010", mem_addr, mem_wdata, mem_funct3); else pass_cnt++;
    @(negedge clk);
    clear_inputs();
    #1;
    chk_cnt++; if (mem_en !== 1'b0 || cpu_rvalid !== 1'b0)
      $display("FAIL store_after: got en=%b rvalid=%b want 0 0", mem_en, cpu_rvalid); else pass_cnt++;
  endtask

  task automatic test_cpu_load();
    @(negedge clk);
    cpu_cmd(1'b0, 32'h0000_0104, '0, 3'b010);
    #1;
    chk_cnt++; if ({cpu_stall, mem_en, mem_wren, cpu_rvalid} !== 4'b1100 || mem_addr !== 32'h104)
      $display("FAIL load_issue: got stall/en/wren/rv=%b addr=%h want 1100 00000104", {cpu_stall, mem_en, mem_wren, cpu_rvalid}, mem_addr); else pass_cnt++;
    @(negedge clk);
    mem_rdata = 32'h1234_5678;
    #1;
    chk_cnt++; if ({cpu_stall, cpu_rvalid, mem_en} !== 3'b010)
      $display("FAIL load_return_ctrl: got stall/rv/en=%b want 010", {cpu_stall, cpu_rvalid, mem_en}); else pass_cnt++;
    chk_cnt++; if (cpu_rdata !== 32'h1234_5678) $display("FAIL load_return_data: got %h want 12345678", cpu_rdata); else pass_cnt++;
    @(negedge clk);
    cpu_req = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk_cnt++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h1234_5678)
      $display("FAIL load_hold: got rv=%b rdata=%h want 0 12345678", cpu_rvalid, cpu_rdata); else pass_cnt++;
    idle_cycles(5);
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_cmd(1'b1, 32'h0000_0300 + 32'(4 * i), 32'h5000_0000 + 32'(i), 3'b000);
      dbg_req = 1'b1; dbg_wren = 1'b0; dbg_addr = 32'h0000_0400;
      #1;
      chk_cnt++; if ({dbg_gnt, cpu_stall, mem_en, mem_wren} !== 4'b0011 || mem_addr !== 32'h0000_0300 + 32'(4 * i))
        $display("FAIL starve_cpu_win%0d: got gnt/stall/en/wren=%b addr=%h want 0011 %h", i, {dbg_gnt, cpu_stall, mem_en, mem_wren}, mem_addr, 32'h0000_0300 + 32'(4 * i)); else pass_cnt++;
    end
    @(negedge clk);
    cpu_cmd(1'b1, 32'h0000_0310, 32'h5000_0004, 3'b000);
    #1;
    chk_cnt++; if ({dbg_gnt, cpu_stall, mem_en, mem_wren} !== 4'b1110)
      $display("FAIL starve_dbg_gnt: got gnt/stall/en/wren=%b want 1110", {dbg_gnt, cpu_stall, mem_en, mem_wren}); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 32'h400 || mem_funct3 !== 3'b010)
      $display("FAIL starve_dbg_bus: got addr=%h f3=%b want 00000400 010", mem_addr, mem_funct3); else pass_cnt++;
    @(negedge clk);
    dbg_req = 1'b0; mem_rdata = 32'h0BAD_F00D;
    #1;
    chk_cnt++; if ({dbg_rvalid, cpu_stall, mem_en, cpu_rvalid} !== 4'b1100 || dbg_rdata !== 32'h0BAD_F00D)
      $display("FAIL starve_dbg_return: got rv/stall/en/cpu_rv=%b rdata=%h want 1100 0badf00d", {dbg_rvalid, cpu_stall, mem_en, cpu_rvalid}, dbg_rdata); else pass_cnt++;
    @(negedge clk);
    mem_rdata = '0;
    #1;
    chk_cnt++; if ({cpu_stall, mem_en, mem_wren} !== 3'b011 || mem_addr !== 32'h310)
      $display("FAIL starve_cpu_resume: got stall/en/wren=%b addr=%h want 011 00000310", {cpu_stall, mem_en, mem_wren}, mem_addr); else pass_cnt++;
    @(negedge clk);
    clear_inputs();
    #1;
    chk_cnt++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0BAD_F00D)
      $display("FAIL starve_dbg_hold: got rv=%b rdata=%h want 0 0badf00d", dbg_rvalid, dbg_rdata); else pass_cnt++;
    idle_cycles(5);
  endtask

  task automatic test_collision();
    @(negedge clk);
    cpu_cmd(1'b0, 32'h0000_0500, '0, 3'b001);
    dbg_req = 1'b1; dbg_wren = 1'b1; dbg_addr = 32'h0000_0200; dbg_wdata = 32'hA5A5_A5A5;
    #1;
    chk_cnt++; if ({mem_en, mem_wren, cpu_stall, dbg_gnt} !== 4'b1010 || mem_addr !== 32'h500 || mem_funct3 !== 3'b001)
      $display("FAIL coll_cpu_first: got en/wren/stall/gnt=%b addr=%h f3=%b want 1010 00000500 001", {mem_en, mem_wren, cpu_stall, dbg_gnt}, mem_addr, mem_funct3); else pass_cnt++;
    @(negedge clk);
    mem_rdata = 32'h0000_7777;
    #1;
    chk_cnt++; if ({cpu_rvalid, cpu_stall, mem_en, dbg_gnt} !== 4'b1000 || cpu_rdata !== 32'h7777)
      $display("FAIL coll_cpu_return: got rv/stall/en/gnt=%b rdata=%h want 1000 00007777", {cpu_rvalid, cpu_stall, mem_en, dbg_gnt}, cpu_rdata); else pass_cnt++;
    @(negedge clk);
    cpu_req = 1'b0; mem_rdata = '0;
    #1;
    chk_cnt++; if ({dbg_gnt, mem_en, mem_wren, cpu_stall} !== 4'b1110)
      $display("FAIL coll_dbg_gnt: got gnt/en/wren/stall=%b want 1110", {dbg_gnt, mem_en, mem_wren, cpu_stall}); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 32'h200 || mem_wdata !== 32'hA5A5_A5A5 || mem_funct3 !== 3'b010)
      $display("FAIL coll_dbg_bus: got addr=%h wdata=%h f3=%b want 00000200 a5a5a5a5 010", mem_addr, mem_wdata, mem_funct3); else pass_cnt++;
    @(negedge clk);
    clear_inputs();
    #1;
    chk_cnt++; if ({dbg_gnt, mem_en, dbg_rvalid} !== 3'b000)
      $display("FAIL coll_after: got gnt/en/rv=%b want 000", {dbg_gnt, mem_en, dbg_rvalid}); else pass_cnt++;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_read();
    int rv_seen;
    @(negedge clk);
    clear_inputs(); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cpu_cmd(1'b0, 32'h0000_0600, '0, 3'b010);
    #1;
    chk_cnt++; if ({cpu_stall3, mem_en3} !== 2'b11)
      $display("FAIL rmr_issue: got stall/en=%b want 11", {cpu_stall3, mem_en3}); else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++; if ({cpu_stall3, cpu_rvalid3, mem_en3} !== 3'b100)
      $display("FAIL rmr_wait1: got stall/rv/en=%b want 100", {cpu_stall3, cpu_rvalid3, mem_en3}); else pass_cnt++;
    @(negedge clk);
    #1 rst = 1'b1; cpu_req = 1'b0;
    #1;
    chk_cnt++; if ({cpu_stall3, cpu_rvalid3, mem_en3} !== 3'b000)
      $display("FAIL rmr_in_reset: got stall/rv/en=%b want 000", {cpu_stall3, cpu_rvalid3, mem_en3}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; mem_rdata = 32'hDEAD_0001;
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (cpu_rvalid3 === 1'b1) rv_seen++;
      @(negedge clk);
    end
    chk_cnt++; if (rv_seen != 0 || cpu_rdata3 !== 32'h0)
      $display("FAIL rmr_no_rvalid: got %0d rvalid cycles rdata=%h want 0 00000000", rv_seen, cpu_rdata3); else pass_cnt++;
    cpu_cmd(1'b0, 32'h0000_0604, '0, 3'b010);
    mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++; if ({cpu_stall3, cpu_rvalid3} !== 2'b10)
        $display("FAIL rmr_reload_stall%0d: got stall/rv=%b want 10", i, {cpu_stall3, cpu_rvalid3}); else pass_cnt++;
      @(negedge clk);
    end
    mem_rdata = 32'h1357_2468;
    #1;
    chk_cnt++; if ({cpu_stall3, cpu_rvalid3} !== 2'b01 || cpu_rdata3 !== 32'h1357_2468)
      $display("FAIL rmr_reload_return: got stall/rv=%b rdata=%h want 01 13572468", {cpu_stall3, cpu_rvalid3}, cpu_rdata3); else pass_cnt++;
    @(negedge clk);
    clear_inputs();
    #1;
    chk_cnt++; if (cpu_rvalid3 !== 1'b0 || cpu_rdata3 !== 32'h1357_2468)
      $display("FAIL rmr_reload_hold: got rv=%b rdata=%h want 0 13572468", cpu_rvalid3, cpu_rdata3); else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_cycles(1);
    test_reset();
    test_cpu_store();
    test_cpu_load();
    test_starvation();
    test_collision();
    test_reset_mid_read();
    idle_cycles(1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
